// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Parametrised VGA timing generator with a pixel fetch handshake.
// Stage 0 is the hc/vc raster counter. Stage 1 registers the request
// (o_req/o_x/o_y) to the upstream pixel source. Sync, blank and active
// flags then travel through a PIX_LAT-deep delay line, so the DAC pins
// line up with the pixel data that comes back. Total latency from a
// stage-0 counter value to the pins is PIX_LAT+2 cycles.
//
// Optional feature: define VGA_TEST_PATTERN_EN to add input i_pattern.
// While i_pattern is high, 8 vertical colour bars replace the pixel data.
//
// Ports:
//   i_clk, i_rst          pixel clock, asynchronous active-low reset
//   i_start, i_stop       level controls: begin scanning / stop at frame end
//   i_pattern             (VGA_TEST_PATTERN_EN only) colour-bar override
//   i_pix_R/G/B           pixel data, valid PIX_LAT cycles after o_req
//   o_req, o_x, o_y       pixel request and its active-area coordinates
//   o_frame_start         one-cycle pulse at the start of each frame
//   o_busy                high while not idle
//   o_VGA_R/G/B           DAC colour
//   o_VGA_HS/VS           sync outputs, polarity set by HS_POL/VS_POL
//   o_VGA_blank           low = blank
//   o_VGA_sync            tied low
//   o_VGA_clk             copy of i_clk for the DAC
module vga_timing_gen #(
  parameter int H_ACT   = 640,
  parameter int H_FRONT = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int V_ACT   = 480,
  parameter int V_FRONT = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33,
  parameter int HS_POL  = 0,
  parameter int VS_POL  = 0,
  parameter int PIX_LAT = 2,
  parameter int CW      = 11
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_stop,
`ifdef VGA_TEST_PATTERN_EN
  input  logic          i_pattern,
`endif
  input  logic [7:0]    i_pix_R,
  input  logic [7:0]    i_pix_G,
  input  logic [7:0]    i_pix_B,
  output logic          o_req,
  output logic [CW-1:0] o_x,
  output logic [CW-1:0] o_y,
  output logic          o_frame_start,
  output logic          o_busy,
  output logic [7:0]    o_VGA_R,
  output logic [7:0]    o_VGA_G,
  output logic [7:0]    o_VGA_B,
  output logic          o_VGA_HS,
  output logic          o_VGA_VS,
  output logic          o_VGA_blank,
  output logic          o_VGA_sync,
  output logic          o_VGA_clk
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACT + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACT + V_FRONT;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_BEG    = CW'(H_SYNC + H_BACK);
  localparam logic [CW-1:0] H_END    = CW'(H_SYNC + H_BACK + H_ACT);
  localparam logic [CW-1:0] V_BEG    = CW'(V_SYNC + V_BACK);
  localparam logic [CW-1:0] V_END    = CW'(V_SYNC + V_BACK + V_ACT);
  localparam logic [CW-1:0] H_SY_END = CW'(H_SYNC);
  localparam logic [CW-1:0] V_SY_END = CW'(V_SYNC);
  localparam logic          HS_ON    = (HS_POL != 0);
  localparam logic          VS_ON    = (VS_POL != 0);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state;
  logic [CW-1:0] hc;
  logic [CW-1:0] vc;

  logic          running;
  logic          line_end;
  logic          frame_end;
  logic          act0;
  logic          hs0;
  logic          vs0;
  logic [CW-1:0] x0;
  logic [CW-1:0] y0;

  logic [PIX_LAT:0] act_d;
  logic [PIX_LAT:0] hs_d;
  logic [PIX_LAT:0] vs_d;

  assign running   = (state != IDLE);
  assign line_end  = (hc == H_LAST);
  assign frame_end = line_end && (vc == V_LAST);

  assign act0 = running && (hc >= H_BEG) && (hc < H_END) && (vc >= V_BEG) && (vc < V_END);
  assign hs0  = running && (hc < H_SY_END);
  assign vs0  = running && (vc < V_SY_END);
  assign x0   = hc - H_BEG;
  assign y0   = vc - V_BEG;

  assign o_busy     = running;
  assign o_req      = act_d[0];
  assign o_VGA_sync = 1'b0;
  assign o_VGA_clk  = i_clk;

  // Control FSM and raster counters. The counters sit at 0 while idle,
  // so the first RUN cycle is the first cycle of hsync on line 0.
  // Cancelling a drain takes priority over finishing the frame.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= IDLE;
      hc    <= '0;
      vc    <= '0;
    end else begin
      case (state)
        IDLE: begin
          hc <= '0;
          vc <= '0;
          if (i_start && !i_stop) state <= RUN;
        end
        RUN, DRAIN: begin
          if (line_end) begin
            hc <= '0;
            vc <= (vc == V_LAST) ? '0 : vc + CW'(1);
          end else begin
            hc <= hc + CW'(1);
          end
          if (state == RUN) begin
            if (i_stop) state <= DRAIN;
          end else if (i_start && !i_stop) begin
            state <= RUN;
          end else if (frame_end) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage-1 request registers plus the flag delay line. Bit 0 of each
  // delay vector is the stage-1 copy (bit 0 of act_d is o_req). The line
  // is flushed while idle. The tail it cuts off lies in the vertical front
  // porch, so no visible pixel is lost.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_x           <= '0;
      o_y           <= '0;
      o_frame_start <= 1'b0;
      act_d         <= '0;
      hs_d          <= '0;
      vs_d          <= '0;
    end else begin
      o_x           <= act0 ? x0 : '0;
      o_y           <= act0 ? y0 : '0;
      o_frame_start <= running && (hc == '0) && (vc == '0);
      if (running) begin
        act_d <= {act_d[PIX_LAT-1:0], act0};
        hs_d  <= {hs_d[PIX_LAT-1:0], hs0};
        vs_d  <= {vs_d[PIX_LAT-1:0], vs0};
      end else begin
        act_d <= '0;
        hs_d  <= '0;
        vs_d  <= '0;
      end
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  // Colour-bar index travels with the flags, so the pattern has the same
  // latency as real pixel data. Columns beyond bar 7 (H_ACT not a
  // multiple of 8) stay black.
  localparam int BAR_W = (H_ACT / 8 > 0) ? H_ACT / 8 : 1;

  logic [CW-1:0]          bar_full;
  logic [2:0]             bar0;
  logic [3*PIX_LAT+2:0]   bar_d;
  logic [2:0]             bar_out;

  assign bar_full = x0 / CW'(BAR_W);
  assign bar0     = (bar_full > CW'(7)) ? 3'd7 : bar_full[2:0];
  assign bar_out  = bar_d[3*PIX_LAT +: 3];

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) bar_d <= '0;
    else        bar_d <= {bar_d[3*PIX_LAT-1:0], bar0};
  end
`endif

  // DAC output register. It samples i_pix on the cycle that matches the
  // delayed active flag, and drives inactive sync levels while idle.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_VGA_HS    <= ~HS_ON;
      o_VGA_VS    <= ~VS_ON;
      o_VGA_blank <= 1'b0;
      o_VGA_R     <= 8'd0;
      o_VGA_G     <= 8'd0;
      o_VGA_B     <= 8'd0;
    end else begin
      o_VGA_HS    <= (running && hs_d[PIX_LAT]) ? HS_ON : ~HS_ON;
      o_VGA_VS    <= (running && vs_d[PIX_LAT]) ? VS_ON : ~VS_ON;
      o_VGA_blank <= running && act_d[PIX_LAT];
      if (running && act_d[PIX_LAT]) begin
`ifdef VGA_TEST_PATTERN_EN
        if (i_pattern) begin
          o_VGA_R <= {8{~bar_out[1]}};
          o_VGA_G <= {8{~bar_out[2]}};
          o_VGA_B <= {8{~bar_out[0]}};
        end else begin
          o_VGA_R <= i_pix_R;
          o_VGA_G <= i_pix_G;
          o_VGA_B <= i_pix_B;
        end
`else
        o_VGA_R <= i_pix_R;
        o_VGA_G <= i_pix_G;
        o_VGA_B <= i_pix_B;
`endif
      end else begin
        o_VGA_R <= 8'd0;
        o_VGA_G <= 8'd0;
        o_VGA_B <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
// Self-checking bench for vga_timing_gen, using a small raster so that
// whole frames fit in a short run. A reference model tracks the scan as a
// single frame position and derives every pin from it arithmetically. A
// stub pixel source answers each o_req PIX_LAT cycles later and drives
// random junk on idle cycles.
module tb_vga_timing_gen;

  localparam int H_ACT = 8, H_FRONT = 2, H_SYNC = 2, H_BACK = 2;
  localparam int V_ACT = 4, V_FRONT = 1, V_SYNC = 1, V_BACK = 1;
  localparam int HS_POL = 1, VS_POL = 1, PIX_LAT = 2, CW = 11;
  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACT + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACT + V_FRONT;
  localparam int F_TOTAL = H_TOTAL * V_TOTAL;
  localparam int L       = PIX_LAT + 2;
  localparam int REQ_LAT = (V_SYNC + V_BACK) * H_TOTAL + H_SYNC + H_BACK + 1;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_start = 1'b0;
  logic          i_stop = 1'b0;
  logic [7:0]    i_pix_R = 8'd0, i_pix_G = 8'd0, i_pix_B = 8'd0;
  logic          o_req, o_frame_start, o_busy;
  logic [CW-1:0] o_x, o_y;
  logic [7:0]    o_VGA_R, o_VGA_G, o_VGA_B;
  logic          o_VGA_HS, o_VGA_VS, o_VGA_blank, o_VGA_sync, o_VGA_clk;
`ifdef VGA_TEST_PATTERN_EN
  logic          i_pattern = 1'b0;
`endif

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACT(H_ACT), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_ACT(V_ACT), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .PIX_LAT(PIX_LAT), .CW(CW)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_stop(i_stop),
`ifdef VGA_TEST_PATTERN_EN
    .i_pattern(i_pattern),
`endif
    .i_pix_R(i_pix_R), .i_pix_G(i_pix_G), .i_pix_B(i_pix_B),
    .o_req(o_req), .o_x(o_x), .o_y(o_y), .o_frame_start(o_frame_start),
    .o_busy(o_busy), .o_VGA_R(o_VGA_R), .o_VGA_G(o_VGA_G), .o_VGA_B(o_VGA_B),
    .o_VGA_HS(o_VGA_HS), .o_VGA_VS(o_VGA_VS), .o_VGA_blank(o_VGA_blank),
    .o_VGA_sync(o_VGA_sync), .o_VGA_clk(o_VGA_clk)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: busy/draining flags plus the frame position of stage 0.
  // h_run/h_pos hold the stage-0 history, where entry 0 is the previous cycle.
  bit m_busy, m_draining;
  int m_pos;
  bit h_run [0:7];
  int h_pos [0:7];

  // Stub history of DUT requests; entry 0 is the current cycle.
  bit req_q [0:7];
  int x_q   [0:7];
  int y_q   [0:7];

  int cyc = 0, run_start = -1, first_req = -1;
  int win_req, win_hs, win_vs, win_fs;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: observed %0d, expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic bit isActive(input int pos);
    int hc, vc;
    hc = pos % H_TOTAL;
    vc = pos / H_TOTAL;
    return (hc >= H_SYNC + H_BACK) && (hc < H_SYNC + H_BACK + H_ACT) &&
           (vc >= V_SYNC + V_BACK) && (vc < V_SYNC + V_BACK + V_ACT);
  endfunction

  function automatic logic [23:0] pixelOf(input int x, input int y);
    logic [7:0] r, g, b;
    r = 8'(x + 16 * y);
    g = 8'((3 * x) ^ y);
    b = 8'(255 - x - y);
    return {r, g, b};
  endfunction

  task automatic modelReset();
    m_busy = 0;
    m_draining = 0;
    m_pos = 0;
    for (int i = 0; i < 8; i++) begin
      h_run[i] = 0; h_pos[i] = 0;
      req_q[i] = 0; x_q[i] = 0; y_q[i] = 0;
    end
  endtask

  task automatic modelEdge();
    int old_pos;
    for (int i = 7; i > 0; i--) begin
      h_run[i] = h_run[i-1];
      h_pos[i] = h_pos[i-1];
    end
    h_run[0] = m_busy;
    h_pos[0] = m_pos;
    old_pos = m_pos;
    m_pos = m_busy ? (m_pos + 1) % F_TOTAL : 0;
    if (!m_busy) begin
      if (i_start && !i_stop) begin m_busy = 1; m_draining = 0; end
    end else if (!m_draining) begin
      if (i_stop) m_draining = 1;
    end else begin
      if (i_start && !i_stop) m_draining = 0;
      else if (old_pos == F_TOTAL - 1) begin m_busy = 0; m_draining = 0; end
    end
  endtask

  task automatic checkAll();
    bit act, blk, hs, vs;
    int x, y, px, py;
    logic [23:0] rgb;
    act = h_run[0] && isActive(h_pos[0]);
    x = h_pos[0] % H_TOTAL - (H_SYNC + H_BACK);
    y = h_pos[0] / H_TOTAL - (V_SYNC + V_BACK);
    checkOutput("busy", o_busy, m_busy);
    checkOutput("req", o_req, act);
    checkOutput("x", o_x, act ? x : 0);
    checkOutput("y", o_y, act ? y : 0);
    checkOutput("frame_start", o_frame_start, h_run[0] && h_pos[0] == 0);
    blk = h_run[L-1] && isActive(h_pos[L-1]);
    hs  = h_run[L-1] && (h_pos[L-1] % H_TOTAL < H_SYNC);
    vs  = h_run[L-1] && (h_pos[L-1] / H_TOTAL < V_SYNC);
    px  = h_pos[L-1] % H_TOTAL - (H_SYNC + H_BACK);
    py  = h_pos[L-1] / H_TOTAL - (V_SYNC + V_BACK);
    rgb = blk ? pixelOf(px, py) : 24'd0;
    checkOutput("hs", o_VGA_HS, hs ? HS_POL : 1 - HS_POL);
    checkOutput("vs", o_VGA_VS, vs ? VS_POL : 1 - VS_POL);
    checkOutput("blank", o_VGA_blank, blk);
    checkOutput("rgb", {o_VGA_R, o_VGA_G, o_VGA_B}, rgb);
    checkOutput("vga_sync", o_VGA_sync, 0);
    checkOutput("vga_clk", o_VGA_clk, clk);
  endtask

  // The stub answers the request seen PIX_LAT cycles ago, or drives junk.
  task automatic applyStimulus(input logic start, input logic stop);
    i_start = start;
    i_stop  = stop;
    for (int i = 7; i > 0; i--) begin
      req_q[i] = req_q[i-1]; x_q[i] = x_q[i-1]; y_q[i] = y_q[i-1];
    end
    req_q[0] = o_req;
    x_q[0]   = int'(o_x);
    y_q[0]   = int'(o_y);
    if (req_q[PIX_LAT]) {i_pix_R, i_pix_G, i_pix_B} = pixelOf(x_q[PIX_LAT], y_q[PIX_LAT]);
    else {i_pix_R, i_pix_G, i_pix_B} = 24'($urandom);
  endtask

  task automatic cycle(input logic start, input logic stop);
    bit was_busy;
    @(posedge clk);
    cyc++;
    was_busy = m_busy;
    if (i_rst) modelEdge();
    if (m_busy && !was_busy) run_start = cyc;
    #1;
    checkAll();
    if (o_req && first_req < 0) first_req = cyc;
    if (o_req) win_req++;
    if (o_VGA_HS == 1'(HS_POL)) win_hs++;
    if (o_VGA_VS == 1'(VS_POL)) win_vs++;
    if (o_frame_start) win_fs++;
    applyStimulus(start, stop);
  endtask

  task automatic clearWindow();
    win_req = 0; win_hs = 0; win_vs = 0; win_fs = 0;
  endtask

  // Asynchronous reset in the middle of a cycle: outputs must drop at once.
  task automatic midReset();
    #2;
    i_rst = 1'b0;
    #1;
    modelReset();
    checkAll();
    cycle(0, 0);
    cycle(0, 0);
    i_rst = 1'b1;
  endtask

  task automatic measureLatency(input string tag);
    first_req = -1;
    cycle(1, 0);
    for (int i = 0; i < 4 * F_TOTAL && first_req < 0; i++) cycle(0, 0);
    checkOutput(tag, (first_req >= 0) ? first_req - run_start : 0, REQ_LAT);
  endtask

  initial begin
    int r;
    modelReset();
    #1 i_rst = 1'b0;
    #1 checkAll();
    repeat (3) cycle(0, 0);
    i_rst = 1'b1;
    cycle(0, 0);

    // Start from idle and check the first request latency.
    measureLatency("first_req_latency");

    // One full frame of steady scanning.
    clearWindow();
    repeat (F_TOTAL) cycle(0, 0);
    checkOutput("frame_req_count", win_req, H_ACT * V_ACT);
    checkOutput("frame_hs_cycles", win_hs, H_SYNC * V_TOTAL);
    checkOutput("frame_vs_cycles", win_vs, V_SYNC * H_TOTAL);
    checkOutput("frame_start_count", win_fs, 1);

    // Stop mid-frame; busy must fall at the end of this frame.
    repeat (20) cycle(0, 0);
    cycle(0, 1);
    for (int i = 0; i < 2 * F_TOTAL && o_busy; i++) cycle(0, 0);
    checkOutput("stop_drained", o_busy, 0);
    clearWindow();
    repeat (F_TOTAL) cycle(0, 0);
    checkOutput("idle_frame_start", win_fs, 0);
    checkOutput("idle_req", win_req, 0);

    // Reset in the middle of a frame, then restart.
    cycle(1, 0);
    repeat (40 + $urandom_range(0, 30)) cycle(0, 0);
    midReset();
    measureLatency("latency_after_reset");

    // Random start/stop traffic with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 999);
      if (r == 999) midReset();
      else cycle(r < 20, r >= 12 && r < 24);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA timing generator with pixel fetch handshake. It is the successor to the team's fixed 640x480 solid-colour display block. All porch, sync and active widths are parameters, and sync polarity is configurable. It issues coordinate requests to an upstream pixel source such as a framebuffer or renderer, then re-aligns the returned pixel data with sync and blank. It sits between the frame buffer and the ADV7123-style DAC pins on the board.

## Interface
Parameters:
- H_ACT, 640, active pixels per line
- H_FRONT, 16, horizontal front porch, in cycles
- H_SYNC, 96, hsync width, in cycles
- H_BACK, 48, horizontal back porch, in cycles
- V_ACT, 480, active lines per frame
- V_FRONT, 10, vertical front porch, in lines
- V_SYNC, 2, vsync width, in lines
- V_BACK, 33, vertical back porch, in lines
- HS_POL, 0, active level of o_VGA_HS (0 = active-low)
- VS_POL, 0, active level of o_VGA_VS
- PIX_LAT, 2, fixed upstream read latency in cycles, must be ≥1
- CW, 11, counter width; H_TOTAL and V_TOTAL must both be < 2^CW

Ports:
- i_clk  in  1  pixel clock
- i_rst  in  1  asynchronous active-low reset
- i_start  in  1  level; begin scanning
- i_stop  in  1  level; stop at end of current frame
- i_pix_R / i_pix_G / i_pix_B  in  8 each  pixel data, PIX_LAT cycles after o_req
- o_req  out  1  pixel request for (o_x, o_y)
- o_x  out  CW  requested column, 0..H_ACT-1
- o_y  out  CW  requested row, 0..V_ACT-1
- o_frame_start  out  1  one-cycle pulse at the start of each frame
- o_busy  out  1  high whenever the state is not IDLE
- o_VGA_R / o_VGA_G / o_VGA_B  out  8 each  DAC colour
- o_VGA_HS / o_VGA_VS  out  1  sync outputs
- o_VGA_blank  out  1  low = blank
- o_VGA_sync  out  1  tied to 0
- o_VGA_clk  out  1  equals i_clk

## Operation
- Totals: H_TOTAL = H_SYNC+H_BACK+H_ACT+H_FRONT; V_TOTAL uses the same formula with the vertical parameters.
- Scan order within a line and within a frame: sync, back porch, active, front porch. Counter value 0 is the first sync cycle.
- Counters hc and vc are stage 0.
  - hc wraps from H_TOTAL-1 to 0 and increments vc on that wrap.
  - vc wraps from V_TOTAL-1 to 0.
- A position is active when H_SYNC+H_BACK ≤ hc < H_SYNC+H_BACK+H_ACT, and the same condition holds for vc with the vertical parameters.
- Stage 1 registers:
  - o_req = RUN/DRAIN and active.
  - o_x = hc-(H_SYNC+H_BACK) and o_y = vc-(V_SYNC+V_BACK). Both hold 0 when o_req is low.
  - o_frame_start is high when hc==0 and vc==0.
- Sync, blank and active flags travel through a delay line so the DAC pins are aligned with the returned pixel data.
- RGB is i_pix registered when the delayed active flag is set, and 0 otherwise.
- State machine:
  - IDLE: counters held at 0. If i_start and not i_stop, go to RUN.
  - RUN: if i_stop, go to DRAIN.
  - DRAIN: if i_start and not i_stop, return to RUN (stop cancelled). On the last cycle of the frame (hc==H_TOTAL-1, vc==V_TOTAL-1), go to IDLE.
- In IDLE:
  - o_VGA_HS = !HS_POL and o_VGA_VS = !VS_POL.
  - blank = 0, RGB = 0, o_req = 0.
  - The delay line is flushed to inactive values. The truncated tail falls in vertical front porch, so no visible pixels are lost.
- i_start is ignored while in RUN.
- Reset state: every output is at its IDLE value, o_busy = 0, and o_frame_start = 0.

## Timing
- L = PIX_LAT+2. This is the number of cycles from a stage-0 counter value to the DAC pins.
- o_req, o_x, o_y and o_frame_start appear 1 cycle after the counter value they reflect.
- i_pix is sampled exactly PIX_LAT cycles after the matching o_req and appears on the pins 1 cycle later.
- hsync is active for exactly H_SYNC cycles per line. vsync is active for exactly V_SYNC*H_TOTAL cycles per frame, beginning on the same cycle as the hsync of line 0.
- Leaving IDLE: the first o_req occurs at cycle (V_SYNC+V_BACK)*H_TOTAL+H_SYNC+H_BACK+1 after the first RUN cycle.
- Asynchronous reset mid-frame: all outputs are forced immediately to reset values. There is no partial-frame completion.

## Configuration
- VGA_TEST_PATTERN_EN:
  - When defined: adds input i_pattern (1 bit). While i_pattern is high, RGB is replaced by 8 vertical colour bars, each H_ACT/8 columns wide. Bar order: white, yellow, cyan, green, magenta, red, blue, black, using component values 255/0. Latency is the same as the i_pix path, and o_req still toggles.
  - When undefined: the port is absent and RGB always comes from i_pix.

## Test plan
- Default parameters, i_start pulse: line period is 800 cycles, hsync is low for 96 cycles per line, vsync is low for 1600 cycles per frame, frame period is 420000 cycles, and there are exactly 307200 o_req per frame.
- Stub source with PIX_LAT=2 returning R=o_x[7:0]: at the first o_VGA_blank rising edge R=0; 10 cycles later R=10; every blank=0 cycle has RGB=0.
- i_stop asserted mid-frame 3: o_busy stays high until the end of frame 3, then falls. There is no o_frame_start for frame 4. Outputs sit at IDLE values.
- i_rst pulled low at hc=300, vc=200: on the same edge, HS/VS go inactive, blank=0, o_req=0, o_busy=0. After i_start, timing restarts at hc=0.
- H_ACT=8, H_FRONT=H_SYNC=H_BACK=2, V_ACT=4, V_FRONT=V_SYNC=V_BACK=1, HS_POL=VS_POL=1: line period is 14, frame period is 98, hsync is high for 2 cycles, and o_x/o_y sweep 0..7 / 0..3.
- With VGA_TEST_PATTERN_EN and i_pattern=1: pixel column 80 outputs R=255, G=255, B=0 (yellow), and column 639 outputs black.
